fft_pe_pipe: RTL and testbench
==============================

# fft_pe_pipe

Parametrised radix-2 FFT processing element with a valid/ready pipeline and a twiddle multiplier. Each accepted beat performs two complex butterflies (in0±in1, in2±in3), optionally scales them by 1/2, and multiplies both difference terms by a common twiddle factor. Arithmetic is rounded and saturated. It is the next-generation PE for the pipelined real-FFT datapath, and it adds back-pressure, stage-level scaling and overflow reporting.

## Interface
- WIDTH, 16: bits per real or imaginary component of data.
- TF_WIDTH, 16: bits per twiddle component (signed fixed point).
- SHIFT, 15: right shift applied to twiddle products (TF_WIDTH-1 gives Q1.(TF_WIDTH-1) twiddles).
- Clk  in  1  clock; every register is on the rising edge.
- Reset_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  PE can accept a beat this cycle.
- in0, in1, in2, in3  in  2*WIDTH each  complex samples: real in [2*WIDTH-1:WIDTH], imaginary in [WIDTH-1:0], signed.
- tf  in  2*TF_WIDTH  twiddle factor, same packing, signed.
- bypass_n  in  1  1 = apply the twiddle to out2/out3; 0 = pass the butterfly differences through.
- scale  in  1  1 = halve the butterfly results.
- out0, out1, out2, out3  out  2*WIDTH each  results, same packing.
- out_valid  out  1  outputs hold a valid beat.
- out_ready  in  1  downstream accepts the beat.
- clr_ovf  in  1  clears the sticky overflow flag.
- ovf  out  1  sticky overflow flag.

## Operation
- The pipeline has three stages: S1 butterfly, S2 twiddle multiply, S3 output register. tf, bypass_n and scale are captured with the data at S1 and travel with it.
- S1, per component, computed signed at WIDTH+1 bits:
  - a = in0+in1, b = in2+in3, c = in0-in1, d = in2-in3.
  - scale=1: result = (x+1)>>>1. This cannot overflow.
  - scale=0: result is saturated to WIDTH bits.
- S2, for c and d (a and b are delayed unchanged):
  - re = cr*tr - ci*ti and im = cr*ti + ci*tr, computed at full precision (WIDTH+TF_WIDTH+1 bits).
  - Rounding: add 2^(SHIFT-1), arithmetic shift right by SHIFT, then saturate to WIDTH bits.
- S3:
  - out0 = a, out1 = b.
  - out2 = bypass_n ? c*tf : c, and out3 = bypass_n ? d*tf : d.
- ovf:
  - Set when any S1 or S2 saturation occurs on a valid beat as it advances.
  - Cleared by clr_ovf. If set and clear happen in the same cycle, set wins.
  - Saturation bounds are +2^(WIDTH-1)-1 and -2^(WIDTH-1).

## Timing
- Pipeline enable: en = !out_valid | out_ready. in_ready = en, and it is combinational.
- A beat is accepted when in_valid & in_ready.
- When en=1, all stages and their valid bits shift together. When en=0, everything holds and out0..3 stay stable.
- Latency is 3 cycles from acceptance to out_valid while unstalled. Throughput is 1 beat/cycle, with a maximum of 3 beats in flight.
- Bubbles (in_valid=0) propagate as invalid slots and are not compressed. Invalid slots never set ovf.
- Reset values: out0..3 = 0, out_valid = 0, ovf = 0, all stage valids = 0.
- A reset mid-operation discards every in-flight beat. in_ready is 1 in the first cycle after reset.
- out_ready=1 with out_valid=0 has no effect beyond keeping the pipeline flowing.

## Configuration
- FFT_PE_SAT_EN defined:
  - Saturation at S1 (scale=0) and S2 as described.
  - ovf is operational.
- FFT_PE_SAT_EN undefined:
  - Results wrap (two's-complement truncation to WIDTH bits). Rounding and scaling are unchanged.
  - ovf is tied to 0 and clr_ovf is ignored.

## Test plan
All scenarios use WIDTH=16, TF_WIDTH=16, SHIFT=15.
- Basic twiddle:
  - Stimulus: in0=(100,50), in1=(20,10), in2=(-30,0), in3=(10,-5), tf=(0x7FFF,0), bypass_n=1, scale=0.
  - Response after 3 cycles: out0=(120,60), out1=(-20,-5), out2=(80,40), out3=(-40,5), ovf=0.
- Twiddle -j:
  - Stimulus: same inputs with tf=(0,0x8000).
  - Response: out2=(40,-80), out3=(5,40).
- Bypass with scale:
  - Stimulus: same inputs, bypass_n=0, scale=1.
  - Response: out0=(60,30), out1=(-10,-2), out2=(40,20), out3=(-20,3).
- Saturation:
  - Stimulus: in0=(0x7FFF,0), in1=(1,0), bypass_n=0, scale=0.
  - Response: out0 real=0x7FFF, out2 real=0x7FFE, ovf=1.
  - ovf stays 1 until clr_ovf is pulsed, then reads 0.
  - With FFT_PE_SAT_EN undefined: out0 real=0x8000, ovf=0.
- Back-pressure:
  - Stimulus: 6 back-to-back beats, with out_ready held 0 from cycle 4 to cycle 8.
  - Response: in_ready=0 while out_valid=1 & out_ready=0, out0..3 stable, no beat lost or duplicated, outputs in order.
- Reset mid-stream:
  - Stimulus: Reset_n=0 for 1 cycle with 3 beats in flight.
  - Response: out_valid=0, outputs=0, ovf=0 next cycle, and none of the 3 beats ever emerge.

Source files
------------

// File: rtl/fft_pe_pipe.sv
// fft_pe_pipe: radix-2 FFT processing element with a 3-stage valid/ready pipeline and twiddle multiply.
// Define FFT_PE_SAT_EN for saturating arithmetic and the sticky ovf flag; otherwise results wrap.
module fft_pe_pipe #(
  parameter int WIDTH    = 16,
  parameter int TF_WIDTH = 16,
  parameter int SHIFT    = 15
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*WIDTH-1:0]    in0,
  input  logic [2*WIDTH-1:0]    in1,
  input  logic [2*WIDTH-1:0]    in2,
  input  logic [2*WIDTH-1:0]    in3,
  input  logic [2*TF_WIDTH-1:0] tf,
  input  logic                  bypass_n,
  input  logic                  scale,
  output logic [2*WIDTH-1:0]    out0,
  output logic [2*WIDTH-1:0]    out1,
  output logic [2*WIDTH-1:0]    out2,
  output logic [2*WIDTH-1:0]    out3,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  clr_ovf,
  output logic                  ovf
);

  // One internal width wide enough for every sum, product and rounding step.
  localparam int PW = WIDTH + TF_WIDTH + 2;
  localparam logic signed [PW-1:0] ONE  = PW'(1);
  localparam logic signed [PW-1:0] RND  = ONE <<< (SHIFT - 1);
  localparam logic signed [PW-1:0] MAXV = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  function automatic logic signed [PW-1:0] sext_d(input logic [WIDTH-1:0] x);
    return {{(PW-WIDTH){x[WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [PW-1:0] sext_t(input logic [TF_WIDTH-1:0] x);
    return {{(PW-TF_WIDTH){x[TF_WIDTH-1]}}, x};
  endfunction

  // Returns {overflow, WIDTH-bit result}.
  function automatic logic [WIDTH:0] clip(input logic signed [PW-1:0] x);
`ifdef FFT_PE_SAT_EN
    if (x > MAXV) return {1'b1, MAXV[WIDTH-1:0]};
    if (x < MINV) return {1'b1, MINV[WIDTH-1:0]};
`endif
    return {1'b0, x[WIDTH-1:0]};
  endfunction

  function automatic logic [WIDTH-1:0] half(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] h;
    h = (x + ONE) >>> 1;
    return h[WIDTH-1:0];
  endfunction

  function automatic logic [2*WIDTH:0] bfly(input logic [2*WIDTH-1:0] p, input logic [2*WIDTH-1:0] q,
                                            input logic sub, input logic sc);
    logic signed [PW-1:0] sr, si;
    logic [WIDTH:0] rr, ri;
    sr = sub ? sext_d(p[2*WIDTH-1:WIDTH]) - sext_d(q[2*WIDTH-1:WIDTH])
             : sext_d(p[2*WIDTH-1:WIDTH]) + sext_d(q[2*WIDTH-1:WIDTH]);
    si = sub ? sext_d(p[WIDTH-1:0]) - sext_d(q[WIDTH-1:0])
             : sext_d(p[WIDTH-1:0]) + sext_d(q[WIDTH-1:0]);
    rr = sc ? {1'b0, half(sr)} : clip(sr);
    ri = sc ? {1'b0, half(si)} : clip(si);
    return {rr[WIDTH] | ri[WIDTH], rr[WIDTH-1:0], ri[WIDTH-1:0]};
  endfunction

  function automatic logic [2*WIDTH:0] cmul(input logic [2*WIDTH-1:0] c, input logic [2*TF_WIDTH-1:0] t);
    logic signed [PW-1:0] cr, ci, tr, ti, re, im;
    logic [WIDTH:0] rr, ri;
    cr = sext_d(c[2*WIDTH-1:WIDTH]);
    ci = sext_d(c[WIDTH-1:0]);
    tr = sext_t(t[2*TF_WIDTH-1:TF_WIDTH]);
    ti = sext_t(t[TF_WIDTH-1:0]);
    re = (cr * tr - ci * ti + RND) >>> SHIFT;
    im = (cr * ti + ci * tr + RND) >>> SHIFT;
    rr = clip(re);
    ri = clip(im);
    return {rr[WIDTH] | ri[WIDTH], rr[WIDTH-1:0], ri[WIDTH-1:0]};
  endfunction

  logic                  en;
  logic                  s1_v, s1_byp, s2_v;
  logic [2*WIDTH-1:0]    s1_a, s1_b, s1_c, s1_d;
  logic [2*WIDTH-1:0]    s2_a, s2_b, s2_c, s2_d;
  logic [2*TF_WIDTH-1:0] s1_tf;
  logic [2*WIDTH:0]      bf_a, bf_b, bf_c, bf_d, mul_c, mul_d;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign bf_a  = bfly(in0, in1, 1'b0, scale);
  assign bf_b  = bfly(in2, in3, 1'b0, scale);
  assign bf_c  = bfly(in0, in1, 1'b1, scale);
  assign bf_d  = bfly(in2, in3, 1'b1, scale);
  assign mul_c = cmul(s1_c, s1_tf);
  assign mul_d = cmul(s1_d, s1_tf);

  // All stages advance together on en; invalid slots keep their stale data.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_v <= 1'b0; s1_byp <= 1'b0; s1_tf <= '0;
      s1_a <= '0; s1_b <= '0; s1_c <= '0; s1_d <= '0;
      s2_v <= 1'b0;
      s2_a <= '0; s2_b <= '0; s2_c <= '0; s2_d <= '0;
      out_valid <= 1'b0;
      out0 <= '0; out1 <= '0; out2 <= '0; out3 <= '0;
    end else if (en) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a   <= bf_a[2*WIDTH-1:0];
        s1_b   <= bf_b[2*WIDTH-1:0];
        s1_c   <= bf_c[2*WIDTH-1:0];
        s1_d   <= bf_d[2*WIDTH-1:0];
        s1_tf  <= tf;
        s1_byp <= bypass_n;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_a <= s1_a;
        s2_b <= s1_b;
        s2_c <= s1_byp ? mul_c[2*WIDTH-1:0] : s1_c;
        s2_d <= s1_byp ? mul_d[2*WIDTH-1:0] : s1_d;
      end
      out_valid <= s2_v;
      if (s2_v) begin
        out0 <= s2_a;
        out1 <= s2_b;
        out2 <= s2_c;
        out3 <= s2_d;
      end
    end
  end

`ifdef FFT_PE_SAT_EN
  logic s1_sat, s2_sat;
  assign s1_sat = in_valid & (bf_a[2*WIDTH] | bf_b[2*WIDTH] | bf_c[2*WIDTH] | bf_d[2*WIDTH]);
  assign s2_sat = s1_v & s1_byp & (mul_c[2*WIDTH] | mul_d[2*WIDTH]);

  // A saturation landing in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge Clk) begin
    if (!Reset_n) ovf <= 1'b0;
    else          ovf <= (ovf & ~clr_ovf) | (en & (s1_sat | s2_sat));
  end
`else
  logic unused_ovf_sources;
  assign unused_ovf_sources = ^{clr_ovf, bf_a[2*WIDTH], bf_b[2*WIDTH], bf_c[2*WIDTH],
                                bf_d[2*WIDTH], mul_c[2*WIDTH], mul_d[2*WIDTH]};
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fft_pe_pipe.sv
// tb_fft_pe_pipe: directed self-checking bench for fft_pe_pipe (WIDTH=16, TF_WIDTH=16, SHIFT=15).
module tb_fft_pe_pipe;
  logic        Clk = 1'b0, Reset_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0, tf = '0;
  logic        bypass_n = 1'b0, scale = 1'b0;
  logic [31:0] out0, out1, out2, out3;
  logic        out_valid, out_ready = 1'b1, clr_ovf = 1'b0, ovf;
  int          vectors = 0, errors = 0;

`ifdef FFT_PE_SAT_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  always #5 Clk = ~Clk;

  fft_pe_pipe #(.WIDTH(16), .TF_WIDTH(16), .SHIFT(15)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .tf(tf),
    .bypass_n(bypass_n), .scale(scale),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .out_ready(out_ready), .clr_ovf(clr_ovf), .ovf(ovf)
  );

  function automatic logic [31:0] cpx(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction

  // Drives one beat for a single cycle; returns at the negedge after it is accepted.
  task automatic send_beat(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                           input logic [31:0] a3, input logic [31:0] t, input logic byp, input logic sc);
    in0 = a0; in1 = a1; in2 = a2; in3 = a3; tf = t; bypass_n = byp; scale = sc;
    in_valid = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    vectors++;
    if ({out_valid, ovf} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_flags: got %b, expected 00", {out_valid, ovf});
    end
    vectors++;
    if ({out0, out1, out2, out3} !== 128'h0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h, expected 0", {out0, out1, out2, out3});
    end
    Reset_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    @(negedge Clk);
  endtask

  task automatic test_basic;
    send_beat(cpx(100, 50), cpx(20, 10), cpx(-30, 0), cpx(10, -5), cpx(32767, 0), 1'b1, 1'b0);
    @(negedge Clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_latency: got out_valid %b, expected 0", out_valid);
    end
    @(negedge Clk);
    vectors++;
    if (out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_valid: got %b, expected 1", out_valid);
    end
    vectors++;
    if ({out0, out1, out2, out3} !== {cpx(120, 60), cpx(-20, -5), cpx(80, 40), cpx(-40, 5)}) begin
      errors++; $display("[TB] FAIL basic_data: got %h, expected %h", {out0, out1, out2, out3},
                         {cpx(120, 60), cpx(-20, -5), cpx(80, 40), cpx(-40, 5)});
    end
    vectors++;
    if (ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_ovf: got %b, expected 0", ovf);
    end
  endtask

  task automatic test_twiddle_j;
    send_beat(cpx(100, 50), cpx(20, 10), cpx(-30, 0), cpx(10, -5), cpx(0, -32768), 1'b1, 1'b0);
    repeat (2) @(negedge Clk);
    vectors++;
    if ({out_valid, out0, out1, out2, out3} !==
        {1'b1, cpx(120, 60), cpx(-20, -5), cpx(40, -80), cpx(5, 40)}) begin
      errors++; $display("[TB] FAIL twiddle_j: got %h, expected %h", {out_valid, out0, out1, out2, out3},
                         {1'b1, cpx(120, 60), cpx(-20, -5), cpx(40, -80), cpx(5, 40)});
    end
  endtask

  task automatic test_bypass_scale;
    send_beat(cpx(100, 50), cpx(20, 10), cpx(-30, 0), cpx(10, -5), cpx(0, -32768), 1'b0, 1'b1);
    repeat (2) @(negedge Clk);
    vectors++;
    if ({out_valid, out0, out1, out2, out3} !==
        {1'b1, cpx(60, 30), cpx(-10, -2), cpx(40, 20), cpx(-20, 3)}) begin
      errors++; $display("[TB] FAIL bypass_scale: got %h, expected %h", {out_valid, out0, out1, out2, out3},
                         {1'b1, cpx(60, 30), cpx(-10, -2), cpx(40, 20), cpx(-20, 3)});
    end
    // Largest possible sums must halve without overflowing.
    send_beat(cpx(32767, -32768), cpx(32767, -32768), 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    repeat (2) @(negedge Clk);
    vectors++;
    if ({out0, out1, out2, out3, ovf} !== {cpx(32767, -32768), 32'h0, 32'h0, 32'h0, 1'b0}) begin
      errors++; $display("[TB] FAIL scale_extreme: got %h, expected %h", {out0, out1, out2, out3, ovf},
                         {cpx(32767, -32768), 32'h0, 32'h0, 32'h0, 1'b0});
    end
  endtask

  task automatic test_saturation;
    logic [31:0] e0;
    e0 = EXP_OVF ? cpx(32767, 0) : cpx(-32768, 0);
    send_beat(cpx(32767, 0), cpx(1, 0), 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge Clk);
    vectors++;
    if ({out0, out1, out2, out3} !== {e0, 32'h0, cpx(32766, 0), 32'h0}) begin
      errors++; $display("[TB] FAIL sat_data: got %h, expected %h", {out0, out1, out2, out3},
                         {e0, 32'h0, cpx(32766, 0), 32'h0});
    end
    vectors++;
    if (ovf !== EXP_OVF) begin
      errors++; $display("[TB] FAIL sat_ovf: got %b, expected %b", ovf, EXP_OVF);
    end
    repeat (3) @(negedge Clk);
    vectors++;
    if (ovf !== EXP_OVF) begin
      errors++; $display("[TB] FAIL ovf_sticky: got %b, expected %b", ovf, EXP_OVF);
    end
    clr_ovf = 1'b1;
    @(negedge Clk);
    clr_ovf = 1'b0;
    vectors++;
    if (ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_clear: got %b, expected 0", ovf);
    end
    clr_ovf = 1'b1;
    send_beat(cpx(32767, 0), cpx(1, 0), 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (ovf !== EXP_OVF) begin
      errors++; $display("[TB] FAIL ovf_set_wins: got %b, expected %b", ovf, EXP_OVF);
    end
    @(negedge Clk);
    clr_ovf = 1'b0;
    vectors++;
    if (ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_clear2: got %b, expected 0", ovf);
    end
  endtask

  task automatic test_twiddle_saturation;
    logic [31:0] e2;
    e2 = EXP_OVF ? cpx(32767, 0) : cpx(-32768, 0);
    send_beat(cpx(-32768, 0), 32'h0, 32'h0, 32'h0, cpx(-32768, 0), 1'b1, 1'b0);
    vectors++;
    if (ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL s1_clean_ovf: got %b, expected 0", ovf);
    end
    repeat (2) @(negedge Clk);
    vectors++;
    if ({out0, out1, out2, out3, ovf} !== {cpx(-32768, 0), 32'h0, e2, 32'h0, EXP_OVF}) begin
      errors++; $display("[TB] FAIL s2_sat: got %h, expected %h", {out0, out1, out2, out3, ovf},
                         {cpx(-32768, 0), 32'h0, e2, 32'h0, EXP_OVF});
    end
    clr_ovf = 1'b1;
    @(negedge Clk);
    clr_ovf = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  // Six beats with out_ready low for cycles 4..8; beat k shows up during the cycles listed in idx.
  task automatic test_back_to_back;
    int sent = 0;
    int idx;
    logic [127:0] exp_data;
    for (int c = 0; c < 16; c++) begin
      out_ready = !(c >= 4 && c <= 8);
      if (sent < 6) begin
        in0 = cpx(10 * (sent + 1), sent + 1); in1 = cpx(1, 1);
        in2 = cpx(sent + 1, 0); in3 = 32'h0; tf = 32'h0;
        bypass_n = 1'b0; scale = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      vectors++;
      if (in_ready !== !(c >= 4 && c <= 8)) begin
        errors++; $display("[TB] FAIL b2b_in_ready c%0d: got %b, expected %b", c, in_ready, !(c >= 4 && c <= 8));
      end
      vectors++;
      if (out_valid !== (c >= 3 && c <= 13)) begin
        errors++; $display("[TB] FAIL b2b_out_valid c%0d: got %b, expected %b", c, out_valid, (c >= 3 && c <= 13));
      end
      if (c >= 3 && c <= 13) begin
        idx = (c == 3) ? 1 : (c <= 9) ? 2 : c - 7;
        exp_data = {cpx(10 * idx + 1, idx + 1), cpx(idx, 0), cpx(10 * idx - 1, idx - 1), cpx(idx, 0)};
        vectors++;
        if ({out0, out1, out2, out3} !== exp_data) begin
          errors++; $display("[TB] FAIL b2b_data c%0d: got %h, expected %h", c, {out0, out1, out2, out3}, exp_data);
        end
      end
      if (in_valid && in_ready) sent++;
      @(negedge Clk);
    end
    vectors++;
    if (sent !== 6) begin
      errors++; $display("[TB] FAIL b2b_accepted: got %0d, expected 6", sent);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 3; i++) begin
      in0 = cpx(32767, 0); in1 = cpx(1, 0); in2 = cpx(i, i); in3 = 32'h0;
      tf = 32'h0; bypass_n = 1'b0; scale = 1'b0; in_valid = 1'b1;
      @(negedge Clk);
    end
    in_valid = 1'b0;
    Reset_n  = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    vectors++;
    if ({out_valid, ovf, in_ready} !== 3'b001) begin
      errors++; $display("[TB] FAIL midreset_flags: got %b, expected 001", {out_valid, ovf, in_ready});
    end
    vectors++;
    if ({out0, out1, out2, out3} !== 128'h0) begin
      errors++; $display("[TB] FAIL midreset_outputs: got %h, expected 0", {out0, out1, out2, out3});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      vectors++;
      if (out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL midreset_ghost cycle%0d: got out_valid %b, expected 0", i, out_valid);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_twiddle_j;
    test_bypass_scale;
    test_saturation;
    test_twiddle_saturation;
    test_back_to_back;
    test_reset_midstream;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
